// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_magnitude_comparator
// Purpose  : Multi-cycle magnitude comparator. Compares two WIDTH-bit operands
//            MSB-first, DIGIT bits per clock, unsigned or two's-complement,
//            with a start/done handshake and registered one-hot gt/eq/lt.
// Ports    : clk, rst (sync, active-high)
//            start_i        - request a compare (accepted when busy_o = 0)
//            a_i, b_i       - operands, sampled on the accepting edge
//            signed_mode_i  - 1 = two's-complement compare, sampled with a/b
//            busy_o         - high while the compare is running
//            done_o         - one-cycle pulse, flags updated this cycle
//            gt_o/eq_o/lt_o - result flags, held until the next done
// Config   : define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing
//            digit (latency 2..N+1); otherwise latency is always N+1.
// Revision : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]    LAST_CNT = CW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_magnitude_comparator: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             dir_q, dir_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_diff;
  logic             w_decided_nx;
  logic             w_dir_nx;
  logic             w_finish;

  // Current digit is always the top DIGIT bits; the registers shift left.
  assign w_da   = sa_q[WIDTH-1 -: DIGIT];
  assign w_db   = sb_q[WIDTH-1 -: DIGIT];
  assign w_diff = (w_da != w_db);

  // The first differing digit decides the result; later digits are ignored.
  assign w_decided_nx = decided_q | w_diff;
  assign w_dir_nx     = decided_q ? dir_q : (w_da > w_db);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_finish = (cnt_q == LAST_CNT) | w_diff;
`else
  assign w_finish = (cnt_q == LAST_CNT);
`endif

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    dir_d     = dir_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RUN;
          // Flipping the sign bit maps two's-complement onto offset-binary,
          // so the serial compare below can stay purely unsigned.
          sa_d      = signed_mode_i ? (a_i ^ MSB_MASK) : a_i;
          sb_d      = signed_mode_i ? (b_i ^ MSB_MASK) : b_i;
          cnt_d     = '0;
          decided_d = 1'b0;
          dir_d     = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d      = sa_q << DIGIT;
        sb_d      = sb_q << DIGIT;
        cnt_d     = cnt_q + CW'(1);
        decided_d = w_decided_nx;
        dir_d     = w_dir_nx;
        if (w_finish) begin
          state_d = S_DONE;
          gt_d    = w_decided_nx & w_dir_nx;
          lt_d    = w_decided_nx & ~w_dir_nx;
          eq_d    = ~w_decided_nx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dir_q     <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      dir_q     <= dir_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign gt_o   = gt_q;
  assign eq_o   = eq_q;
  assign lt_o   = lt_q;

endmodule
`default_nettype wire

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Multi-cycle magnitude comparator: the parametrised successor of the team's single-bit comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, in unsigned or two's-complement mode. It uses a start/done handshake and produces registered one-hot gt/eq/lt flags. It serves datapaths that trade latency for area when comparing wide words.

## Interface
- WIDTH, 8, operand width in bits; WIDTH ≥ 1 and WIDTH % DIGIT == 0.
- DIGIT, 2, bits examined per RUN cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT digits.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a comparison; accepted only when busy = 0.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- signed_mode  input  1  1 = two's-complement compare; sampled with a/b.
- busy  output  1  high while RUN.
- done  output  1  one-cycle pulse; gt/eq/lt updated in this cycle.
- gt  output  1  a > b, registered, held until next done.
- eq  output  1  a == b, registered, held until next done.
- lt  output  1  a < b, registered, held until next done.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start = 1 → RUN.
  - Load shift registers sa/sb from a/b.
  - If signed_mode = 1, invert the MSB of both on load (offset-binary); the compare is then unsigned.
  - Clear the digit counter (ceil(log2(N)) bits, min 1) and the decided flag.
- DONE with start = 0 → IDLE. DONE always lasts exactly one cycle.
- RUN, each cycle: compare the top DIGIT bits of sa vs sb.
  - If not yet decided and they differ, latch dir (1 = A greater) and set decided.
  - Shift sa/sb left by DIGIT. Increment the counter.
- RUN → DONE when counter == N−1. With EARLY_EXIT_EN, also when a digit first differs.
- On entering DONE, write gt = decided & dir, lt = decided & ~dir, eq = ~decided.
- After the first done, exactly one of gt/eq/lt is high.
- start is ignored while busy = 1; it is not queued.
- a, b and signed_mode changing during RUN have no effect.

## Timing
- Reset values: busy = 0, done = 0, gt = 0, eq = 0, lt = 0; FSM = IDLE; shift registers and counter = 0.
- Start accepted at edge 0; busy = 1 in cycles 1..N; digit k is examined in cycle k+1.
- Without early exit: done = 1 and new flags in cycle N+1 (latency N+1 clocks); busy = 0 in that cycle.
- Early exit at digit k: done in cycle k+2.
- Equal operands always take N+1 clocks.
- Back-to-back: start high in the DONE cycle is accepted; the next RUN begins the following cycle, giving a throughput of one result per N+1 cycles.
- rst mid-operation: the next cycle shows reset values, the comparison is aborted, and no done pulse occurs.
- rst wins over a simultaneous start.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN defined: RUN ends on the first differing digit; variable latency 2..N+1.
- SERIAL_CMP_EARLY_EXIT_EN undefined: fixed latency N+1 for all operands.
- gt/eq/lt results are identical in both builds.

## Test plan
All scenarios use WIDTH = 8, DIGIT = 2 (N = 4) unless stated.
- Unsigned: a = 0xA5, b = 0x5A, signed_mode = 0 → done in cycle 5 (macro off), gt = 1, eq = 0, lt = 0.
- Equal: a = b = 0x3C → eq = 1 with done in cycle 5, in both builds.
- Signed vs unsigned: a = 0x80, b = 0x01 → signed_mode = 1 gives lt = 1; signed_mode = 0 gives gt = 1.
- Early exit: a = 0xC0, b = 0x00 → done in cycle 2 with the macro on, cycle 5 with it off; gt = 1 in both.
- Handshake:
  - start held high through RUN → exactly one comparison, no extra done.
  - start in the DONE cycle with new a = 0x01, b = 0x02 → second done 5 cycles later, lt = 1.
- Reset: rst in cycle 2 of a RUN → cycle 3 shows busy = 0, done = 0, gt/eq/lt = 0, and no done follows.
- Repeat the signed/unsigned scenario with WIDTH = 7, DIGIT = 7 (N = 1) → latency 2.
